// File: rtl/mem_stage_unit.sv
// MEM-stage memory unit: word-addressed data memory with sub-word access,
// misalignment detection, and a fixed-priority N-channel buffer-load bypass.
module mem_stage_unit #(
    parameter int P_NUM      = 0,
    parameter int ADDR_BITS  = 10,
    parameter int NUM_BUF    = 2,
    parameter int BUF_ADDR_W = 6
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    EX_MEM_Valid,
    input  logic                    EX_MEM_MemRead,
    input  logic                    EX_MEM_MemWrite,
    input  logic [1:0]              EX_MEM_Size,
    input  logic                    EX_MEM_Unsigned,
    input  logic [31:0]             EX_MEM_ALUResult,
    input  logic [31:0]             EX_MEM_rt_val,
    input  logic [NUM_BUF-1:0]      EX_MEM_load_buff,
    output logic [BUF_ADDR_W-1:0]   buf_val_addr,
    input  logic [32*NUM_BUF-1:0]   buf_val_select,
    output logic [31:0]             MEM_ReadData,
    output logic                    MEM_ReadValid,
    output logic                    MEM_Stall,
    output logic                    MEM_Misaligned
);
    localparam int         DEPTH   = 1 << ADDR_BITS;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic {IDLE, READ_WAIT} state_t;

    state_t      state_q, state_d;
    logic [31:0] read_data_q, read_data_d;
    logic        read_valid_q, read_valid_d;
    logic        misaligned_q, misaligned_d;
    logic [1:0]  size_q, size_d;
    logic        is_unsigned_q, is_unsigned_d;
    logic [1:0]  lane_q, lane_d;

    logic [31:0] mem [DEPTH];
    logic [31:0] mem_rdata_q;

    logic [ADDR_BITS-1:0] word_idx;
    logic [1:0]           byte_off;
    logic                 buf_hit, misaligned, do_mem, do_load, do_store;
    logic [31:0]          buf_data, wr_data, load_ext;
    logic [3:0]           wr_be;
    logic [15:0]          half_sel;
    logic [7:0]           byte_sel;
    logic                 unused_bits;

    assign word_idx     = EX_MEM_ALUResult[ADDR_BITS+1:2];
    assign byte_off     = EX_MEM_ALUResult[1:0];
    assign buf_val_addr = EX_MEM_ALUResult[BUF_ADDR_W-1:0];
    assign buf_hit      = |EX_MEM_load_buff;
    assign unused_bits  = ^{EX_MEM_ALUResult[31:ADDR_BITS+2], 32'(P_NUM)};

    always_comb begin
        case (EX_MEM_Size)
            SZ_HALF: misaligned = byte_off[0];
            SZ_BYTE: misaligned = 1'b0;
            default: misaligned = (byte_off != 2'b00);
        endcase
    end

    // Only an idle FSM accepts a request; the repeat seen in READ_WAIT is dropped.
    assign do_mem    = (state_q == IDLE) && EX_MEM_Valid && !buf_hit;
    assign do_load   = do_mem && EX_MEM_MemRead && !misaligned;
    assign do_store  = do_mem && !EX_MEM_MemRead && EX_MEM_MemWrite && !misaligned;
    assign MEM_Stall = do_load;

    always_comb begin
        buf_data = '0;
        for (int k = NUM_BUF - 1; k >= 0; k--) begin
            if (EX_MEM_load_buff[k]) buf_data = buf_val_select[32*k +: 32];
        end
    end

    always_comb begin
        case (EX_MEM_Size)
            SZ_BYTE: begin
                wr_data = {4{EX_MEM_rt_val[7:0]}};
                wr_be   = 4'b0001 << byte_off;
            end
            SZ_HALF: begin
                wr_data = {2{EX_MEM_rt_val[15:0]}};
                wr_be   = byte_off[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wr_data = EX_MEM_rt_val;
                wr_be   = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (do_store) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
        if (do_load) mem_rdata_q <= mem[word_idx];
    end

    always_comb begin
        half_sel = lane_q[1] ? mem_rdata_q[31:16] : mem_rdata_q[15:0];
        case (lane_q)
            2'd0:    byte_sel = mem_rdata_q[7:0];
            2'd1:    byte_sel = mem_rdata_q[15:8];
            2'd2:    byte_sel = mem_rdata_q[23:16];
            default: byte_sel = mem_rdata_q[31:24];
        endcase
        case (size_q)
            SZ_BYTE: load_ext = is_unsigned_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: load_ext = is_unsigned_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_ext = mem_rdata_q;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        read_data_d   = read_data_q;
        read_valid_d  = 1'b0;
        misaligned_d  = 1'b0;
        size_d        = size_q;
        is_unsigned_d = is_unsigned_q;
        lane_d        = lane_q;
        if (state_q == READ_WAIT) begin
            read_data_d  = load_ext;
            read_valid_d = 1'b1;
            state_d      = IDLE;
        end else if (EX_MEM_Valid) begin
            if (buf_hit) begin
                read_data_d  = buf_data;
                read_valid_d = 1'b1;
            end else if (EX_MEM_MemRead) begin
                if (misaligned) begin
                    read_data_d  = 32'h0;
                    read_valid_d = 1'b1;
                    misaligned_d = 1'b1;
                end else begin
                    state_d       = READ_WAIT;
                    size_d        = EX_MEM_Size;
                    is_unsigned_d = EX_MEM_Unsigned;
                    lane_d        = byte_off;
                end
            end else if (EX_MEM_MemWrite) begin
                misaligned_d = misaligned;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q       <= IDLE;
            read_data_q   <= 32'h0;
            read_valid_q  <= 1'b0;
            misaligned_q  <= 1'b0;
            size_q        <= 2'b00;
            is_unsigned_q <= 1'b0;
            lane_q        <= 2'b00;
        end else begin
            state_q       <= state_d;
            read_data_q   <= read_data_d;
            read_valid_q  <= read_valid_d;
            misaligned_q  <= misaligned_d;
            size_q        <= size_d;
            is_unsigned_q <= is_unsigned_d;
            lane_q        <= lane_d;
        end
    end

    assign MEM_ReadData   = read_data_q;
    assign MEM_ReadValid  = read_valid_q;
    assign MEM_Misaligned = misaligned_q;

endmodule

// File: tb/tb_mem_stage_unit.sv
// Bench for mem_stage_unit: byte-array reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_stage_unit;
    localparam int ADDR_BITS  = 10;
    localparam int NUM_BUF    = 4;
    localparam int BUF_ADDR_W = 6;
    localparam int MEM_BYTES  = 4 << ADDR_BITS;

    logic                   Clk = 1'b0;
    logic                   Rst;
    logic                   EX_MEM_Valid, EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_Unsigned;
    logic [1:0]             EX_MEM_Size;
    logic [31:0]            EX_MEM_ALUResult, EX_MEM_rt_val;
    logic [NUM_BUF-1:0]     EX_MEM_load_buff;
    logic [BUF_ADDR_W-1:0]  buf_val_addr;
    logic [32*NUM_BUF-1:0]  buf_val_select;
    logic [31:0]            MEM_ReadData;
    logic                   MEM_ReadValid, MEM_Stall, MEM_Misaligned;

    int err_count   = 0;
    int check_count = 0;
    bit checking    = 1'b0;

    logic [7:0]  mem_b [MEM_BYTES];
    logic [31:0] exp_rdata;
    logic        exp_rvalid, exp_mis, busy_m;
    logic [31:0] pend_addr;
    logic [1:0]  pend_size;
    logic        pend_uns;
    logic [31:0] r_addr;
    int unsigned kind;

    always #5 Clk = ~Clk;

    mem_stage_unit #(
        .P_NUM(0), .ADDR_BITS(ADDR_BITS), .NUM_BUF(NUM_BUF), .BUF_ADDR_W(BUF_ADDR_W)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .EX_MEM_Valid(EX_MEM_Valid), .EX_MEM_MemRead(EX_MEM_MemRead),
        .EX_MEM_MemWrite(EX_MEM_MemWrite), .EX_MEM_Size(EX_MEM_Size),
        .EX_MEM_Unsigned(EX_MEM_Unsigned), .EX_MEM_ALUResult(EX_MEM_ALUResult),
        .EX_MEM_rt_val(EX_MEM_rt_val), .EX_MEM_load_buff(EX_MEM_load_buff),
        .buf_val_addr(buf_val_addr), .buf_val_select(buf_val_select),
        .MEM_ReadData(MEM_ReadData), .MEM_ReadValid(MEM_ReadValid),
        .MEM_Stall(MEM_Stall), .MEM_Misaligned(MEM_Misaligned)
    );

    function automatic bit is_misaligned(logic [31:0] addr, logic [1:0] size);
        case (size)
            2'b01:   return addr[0];
            2'b10:   return 1'b0;
            default: return addr[1:0] != 2'b00;
        endcase
    endfunction

    function automatic int size_bytes(logic [1:0] size);
        case (size)
            2'b01:   return 2;
            2'b10:   return 1;
            default: return 4;
        endcase
    endfunction

    function automatic int byte_at(logic [31:0] addr, int i);
        return int'(addr % MEM_BYTES) + i;
    endfunction

    function automatic logic [31:0] model_load(logic [31:0] addr, logic [1:0] size, logic uns);
        int a;
        logic [7:0]  b;
        logic [15:0] h;
        a = byte_at(addr, 0);
        case (size)
            2'b10: begin
                b = mem_b[a];
                return uns ? {24'h0, b} : 32'($signed(b));
            end
            2'b01: begin
                h = {mem_b[a+1], mem_b[a]};
                return uns ? {16'h0, h} : 32'($signed(h));
            end
            default: return {mem_b[a+3], mem_b[a+2], mem_b[a+1], mem_b[a]};
        endcase
    endfunction

    function automatic logic [31:0] first_buffer(logic [NUM_BUF-1:0] lb, logic [32*NUM_BUF-1:0] sel);
        for (int i = 0; i < NUM_BUF; i++) begin
            if (lb[i]) return sel[32*i +: 32];
        end
        return 32'h0;
    endfunction

    function automatic logic exp_stall();
        return !busy_m && EX_MEM_Valid && (EX_MEM_load_buff == '0) && EX_MEM_MemRead
               && !is_misaligned(EX_MEM_ALUResult, EX_MEM_Size);
    endfunction

    // Reference model: a pending-load record plus a byte-addressed memory image.
    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            busy_m     <= 1'b0;
            exp_rdata  <= 32'h0;
            exp_rvalid <= 1'b0;
            exp_mis    <= 1'b0;
        end else begin
            exp_rvalid <= 1'b0;
            exp_mis    <= 1'b0;
            if (busy_m) begin
                exp_rdata  <= model_load(pend_addr, pend_size, pend_uns);
                exp_rvalid <= 1'b1;
                busy_m     <= 1'b0;
            end else if (EX_MEM_Valid) begin
                if (EX_MEM_load_buff != '0) begin
                    exp_rdata  <= first_buffer(EX_MEM_load_buff, buf_val_select);
                    exp_rvalid <= 1'b1;
                end else if (EX_MEM_MemRead) begin
                    if (is_misaligned(EX_MEM_ALUResult, EX_MEM_Size)) begin
                        exp_rdata  <= 32'h0;
                        exp_rvalid <= 1'b1;
                        exp_mis    <= 1'b1;
                    end else begin
                        busy_m    <= 1'b1;
                        pend_addr <= EX_MEM_ALUResult;
                        pend_size <= EX_MEM_Size;
                        pend_uns  <= EX_MEM_Unsigned;
                    end
                end else if (EX_MEM_MemWrite) begin
                    if (is_misaligned(EX_MEM_ALUResult, EX_MEM_Size)) begin
                        exp_mis <= 1'b1;
                    end else begin
                        for (int i = 0; i < size_bytes(EX_MEM_Size); i++)
                            mem_b[byte_at(EX_MEM_ALUResult, i)] <= EX_MEM_rt_val[8*i +: 8];
                    end
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (checking) begin
            check_output("read_data", MEM_ReadData, exp_rdata);
            check_output("read_valid", 32'(MEM_ReadValid), 32'(exp_rvalid));
            check_output("misaligned", 32'(MEM_Misaligned), 32'(exp_mis));
            check_output("stall", 32'(MEM_Stall), 32'(exp_stall()));
            check_output("buf_addr", 32'(buf_val_addr), EX_MEM_ALUResult & 32'h3F);
        end
    end

    task automatic set_idle();
        EX_MEM_Valid     = 1'b0;
        EX_MEM_MemRead   = 1'($urandom_range(0, 1));
        EX_MEM_MemWrite  = 1'($urandom_range(0, 1));
        EX_MEM_Size      = 2'($urandom_range(0, 3));
        EX_MEM_Unsigned  = 1'($urandom_range(0, 1));
        EX_MEM_ALUResult = $urandom;
        EX_MEM_rt_val    = $urandom;
        EX_MEM_load_buff = NUM_BUF'($urandom);
        for (int i = 0; i < NUM_BUF; i++) buf_val_select[32*i +: 32] = $urandom;
    endtask

    task automatic drive_req(input logic rd, input logic wr, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] rt, input logic [NUM_BUF-1:0] lb);
        EX_MEM_Valid     = 1'b1;
        EX_MEM_MemRead   = rd;
        EX_MEM_MemWrite  = wr;
        EX_MEM_Size      = size;
        EX_MEM_Unsigned  = uns;
        EX_MEM_ALUResult = addr;
        EX_MEM_rt_val    = rt;
        EX_MEM_load_buff = lb;
    endtask

    // Presents one request; an aligned data load is held for its repeat cycle.
    task automatic apply_stimulus(input logic rd, input logic wr, input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] rt,
                                  input logic [NUM_BUF-1:0] lb, input bit drop_repeat);
        drive_req(rd, wr, size, uns, addr, rt, lb);
        @(posedge Clk); #2;
        if (lb == '0 && rd && !is_misaligned(addr, size)) begin
            if (drop_repeat) EX_MEM_Valid = 1'b0;
            @(posedge Clk); #2;
        end
        set_idle();
    endtask

    task automatic wait_read(input string name, input logic [31:0] exp_data, input logic exp_m);
        bit seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge Clk);
            if (MEM_ReadValid) begin
                seen = 1'b1;
                check_output({name, "_data"}, MEM_ReadData, exp_data);
                check_output({name, "_mis"}, 32'(MEM_Misaligned), 32'(exp_m));
            end
        end
        if (!seen) begin
            check_count++;
            err_count++;
            $display("[TB] FAIL %s_timeout: got no read_valid, expected a pulse", name);
        end
        @(posedge Clk); #2;
    endtask

    initial begin
        Rst = 1'b0;
        set_idle();
        repeat (2) @(posedge Clk);
        #2;
        check_output("reset_read_data", MEM_ReadData, 32'h0);
        check_output("reset_read_valid", 32'(MEM_ReadValid), 32'h0);
        check_output("reset_misaligned", 32'(MEM_Misaligned), 32'h0);
        Rst      = 1'b1;
        checking = 1'b1;
        @(posedge Clk); #2;

        for (int i = 0; i < 16; i++) apply_stimulus(1'b0, 1'b1, 2'b00, 1'b0, 32'(i) << 2, $urandom, '0, 1'b0);

        apply_stimulus(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF, '0, 1'b0);
        drive_req(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, '0);
        @(negedge Clk); check_output("lw_stall_first", 32'(MEM_Stall), 32'h1);
        @(posedge Clk); #2;
        @(negedge Clk); check_output("lw_stall_repeat", 32'(MEM_Stall), 32'h0);
        @(posedge Clk); #2;
        set_idle();
        @(negedge Clk);
        check_output("lw_valid", 32'(MEM_ReadValid), 32'h1);
        check_output("lw_data", MEM_ReadData, 32'hDEADBEEF);
        @(posedge Clk); #2;

        apply_stimulus(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'h11223344, '0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h13, 32'h00000080, '0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, '0, 1'b0);
        wait_read("lb", 32'hFFFFFF80, 1'b0);
        apply_stimulus(1'b1, 1'b0, 2'b10, 1'b1, 32'h13, 32'h0, '0, 1'b1);
        wait_read("lbu", 32'h00000080, 1'b0);
        apply_stimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, '0, 1'b0);
        wait_read("lw_merged", 32'h80223344, 1'b0);

        apply_stimulus(1'b0, 1'b1, 2'b00, 1'b0, 32'h20, 32'h80017FFF, '0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, '0, 1'b0);
        wait_read("lh", 32'hFFFF8001, 1'b0);
        apply_stimulus(1'b1, 1'b0, 2'b01, 1'b0, 32'h21, 32'h0, '0, 1'b0);
        wait_read("lh_misaligned", 32'h0, 1'b1);
        apply_stimulus(1'b0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h12345678, '0, 1'b0);
        @(negedge Clk); check_output("sw_misaligned_pulse", 32'(MEM_Misaligned), 32'h1);
        @(posedge Clk); #2;
        apply_stimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, '0, 1'b0);
        wait_read("lw_unchanged", 32'h80017FFF, 1'b0);

        buf_val_select = {32'hBBBB0003, 32'h22220002, 32'hAAAA0001, 32'h11110000};
        drive_req(1'b1, 1'b0, 2'b00, 1'b0, 32'h2D, 32'h0, 4'b1010);
        @(negedge Clk);
        check_output("buf_addr_literal", 32'(buf_val_addr), 32'h2D);
        check_output("buf_no_stall", 32'(MEM_Stall), 32'h0);
        @(posedge Clk); #2;
        set_idle();
        @(negedge Clk);
        check_output("buf_valid", 32'(MEM_ReadValid), 32'h1);
        check_output("buf_data", MEM_ReadData, 32'hAAAA0001);
        @(posedge Clk); #2;

        apply_stimulus(1'b0, 1'b1, 2'b00, 1'b0, 32'h1000, 32'hCAFEF00D, '0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, '0, 1'b0);
        wait_read("alias", 32'hCAFEF00D, 1'b0);

        drive_req(1'b1, 1'b0, 2'b00, 1'b0, 32'h4, 32'h0, '0);
        @(posedge Clk); #2;
        Rst = 1'b0;
        set_idle();
        @(negedge Clk);
        check_output("midload_reset_data", MEM_ReadData, 32'h0);
        check_output("midload_reset_valid", 32'(MEM_ReadValid), 32'h0);
        @(posedge Clk); #2;
        Rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check_output("no_valid_after_reset", 32'(MEM_ReadValid), 32'h0);
        end
        @(posedge Clk); #2;

        for (int n = 0; n < 300; n++) begin
            kind   = $urandom_range(0, 9);
            r_addr = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2)
                     | ($urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : 32'h0);
            if (kind <= 2) begin
                apply_stimulus(1'b0, 1'b1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                               r_addr, $urandom, '0, 1'b0);
            end else if (kind <= 6) begin
                apply_stimulus(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                               1'($urandom_range(0, 1)), r_addr, $urandom, '0, 1'($urandom_range(0, 1)));
            end else if (kind <= 8) begin
                apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                               1'($urandom_range(0, 1)), r_addr, $urandom,
                               NUM_BUF'($urandom_range(1, (1 << NUM_BUF) - 1)), 1'b0);
            end else begin
                set_idle();
                repeat ($urandom_range(1, 3)) begin
                    @(posedge Clk); #2;
                end
            end
        end

        @(posedge Clk); #2;
        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
